dgf_seq_ctrl: RTL and testbench

//  Sync-domain sequencer for one async feedback deglitch filter on an I2C pad (SCL or SDA).

---
 rtl/dgf_seq_ctrl.sv | 157 +++++++++++++++
 tb/tb_dgf_seq_ctrl.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dgf_seq_ctrl.sv
// Sequencer for one async deglitch filter on an I2C pad: standby, wake, loopback self-test, then run.
// Optional output-edge monitor is built when DGF_MON_EN is defined; otherwise mon_edges reads 0.
module dgf_seq_ctrl #(
    parameter int WAKE_CYC = 16,
    parameter int TO_CYC   = 64,
    parameter int CNT_W    = 8,
    parameter int SYNC_STG = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        cfg_byp,
    input  logic        pad_in,
    input  logic        dg_out,
    input  logic        dg_dout,
    output logic        dg_in,
    output logic        dg_sb,
    output logic        dg_byp,
    output logic        ready,
    output logic        fault,
    output logic [2:0]  st_code,
    output logic [15:0] mon_edges,
    input  logic        mon_clr
);

    typedef enum logic [2:0] {
        ST_OFF    = 3'd0,
        ST_WAKE   = 3'd1,
        ST_TST_LO = 3'd2,
        ST_TST_HI = 3'd3,
        ST_RUN    = 3'd4,
        ST_FAULT  = 3'd5
    } state_t;

    localparam logic [CNT_W-1:0] WAKE_LAST = CNT_W'(WAKE_CYC - 1);
    localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TO_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    state_t             state;
    state_t             state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_nxt;
    logic [SYNC_STG-1:0] out_sync;
    logic [SYNC_STG-1:0] dout_sync;
    logic               dg_out_s;
    logic               dg_dout_s;
    logic               in_r;
    logic               run_sel;

    // Synchronizers idle at 1, matching the filter's standby output.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_sync  <= '1;
            dout_sync <= '1;
        end else begin
            out_sync  <= {out_sync[SYNC_STG-2:0], dg_out};
            dout_sync <= {dout_sync[SYNC_STG-2:0], dg_dout};
        end
    end

    assign dg_out_s  = out_sync[SYNC_STG-1];
    assign dg_dout_s = dout_sync[SYNC_STG-1];

    always_comb begin
        state_nxt = state;
        cnt_nxt   = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
        case (state)
            ST_OFF: begin
                cnt_nxt = '0;
                if (enable) state_nxt = ST_WAKE;
            end
            ST_WAKE: begin
                if (cnt == WAKE_LAST) begin
                    state_nxt = ST_TST_LO;
                    cnt_nxt   = '0;
                end
            end
            ST_TST_LO: begin
                if (!dg_out_s && !dg_dout_s) begin
                    state_nxt = ST_TST_HI;
                    cnt_nxt   = '0;
                end else if (cnt == TO_LAST) begin
                    state_nxt = ST_FAULT;
                end
            end
            ST_TST_HI: begin
                if (dg_out_s && dg_dout_s) begin
                    state_nxt = ST_RUN;
                end else if (cnt == TO_LAST) begin
                    state_nxt = ST_FAULT;
                end
            end
            ST_RUN, ST_FAULT: state_nxt = state;
            default: state_nxt = ST_OFF;
        endcase
        // Dropping enable overrides any test pass or timeout in the same cycle.
        if (!enable) begin
            state_nxt = ST_OFF;
            cnt_nxt   = '0;
        end
    end

    // Outputs are decoded from the next state so they change on the same edge as the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_OFF;
            cnt     <= '0;
            st_code <= 3'd0;
            dg_sb   <= 1'b0;
            dg_byp  <= 1'b1;
            in_r    <= 1'b1;
            run_sel <= 1'b0;
            ready   <= 1'b0;
            fault   <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            st_code <= state_nxt;
            dg_sb   <= !(state_nxt == ST_OFF || state_nxt == ST_FAULT);
            dg_byp  <= (state_nxt == ST_RUN) ? cfg_byp :
                       (state_nxt == ST_OFF || state_nxt == ST_WAKE || state_nxt == ST_FAULT);
            in_r    <= (state_nxt != ST_TST_LO);
            run_sel <= (state_nxt == ST_RUN);
            ready   <= (state_nxt == ST_RUN);
            fault   <= (state_nxt == ST_FAULT);
        end
    end

    // In RUN the pad passes straight through; only the mux select is registered.
    assign dg_in = run_sel ? pad_in : in_r;

`ifdef DGF_MON_EN
    logic        out_prev;
    logic [15:0] mon_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_prev <= 1'b1;
            mon_cnt  <= 16'h0;
        end else begin
            out_prev <= dg_out_s;
            if (mon_clr || state_nxt == ST_OFF) begin
                mon_cnt <= 16'h0;
            end else if (state == ST_RUN && dg_out_s != out_prev && mon_cnt != 16'hFFFF) begin
                mon_cnt <= mon_cnt + 16'h1;
            end
        end
    end

    assign mon_edges = mon_cnt;
`else
    logic unused_mon_clr;
    assign unused_mon_clr = mon_clr;
    assign mon_edges      = 16'h0;
`endif

endmodule

// File: tb/tb_dgf_seq_ctrl.sv
// Self-checking bench for dgf_seq_ctrl with a behavioural filter model (3-cycle delay, stuck-at modes).
module tb_dgf_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        cfg_byp;
    logic        pad_in;
    logic        mon_clr;
    logic        dg_out;
    logic        dg_dout;
    wire         dg_in;
    wire         dg_sb;
    wire         dg_byp;
    wire         ready;
    wire         fault;
    wire  [2:0]  st_code;
    wire  [15:0] mon_edges;

    int checks = 0;
    int errors = 0;
    int mode   = 0;
    logic [2:0] dly = 3'b111;
    logic [2:0] exp_q[$];
    int         mon_q[$];

`ifdef DGF_MON_EN
    localparam bit MON_ON = 1'b1;
`else
    localparam bit MON_ON = 1'b0;
`endif

    dgf_seq_ctrl dut (
        .clk(clk), .rst(rst), .enable(enable), .cfg_byp(cfg_byp), .pad_in(pad_in),
        .dg_out(dg_out), .dg_dout(dg_dout), .dg_in(dg_in), .dg_sb(dg_sb), .dg_byp(dg_byp),
        .ready(ready), .fault(fault), .st_code(st_code), .mon_edges(mon_edges), .mon_clr(mon_clr)
    );

    always #5 clk = ~clk;

    // Filter model: standby forces 1, bypass is transparent, otherwise IN delayed by 3 clocks.
    always @(posedge clk) dly <= {dly[1:0], dg_in};
    assign dg_out  = !dg_sb ? 1'b1 : (mode == 1) ? 1'b1 : dg_byp ? dg_in : dly[2];
    assign dg_dout = !dg_sb ? 1'b1 : (mode == 2) ? 1'b0 : dg_byp ? dg_in : dly[2];

    function automatic int mon_exp(input int n);
        return MON_ON ? n : 0;
    endfunction

    task automatic test_reset();
        rst = 1'b1; enable = 1'b0; cfg_byp = 1'b0; pad_in = 1'b1; mon_clr = 1'b0; mode = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if ({st_code, dg_sb, dg_byp, dg_in, ready, fault, mon_edges} !== {3'd0, 5'b01100, 16'd0}) begin
                errors++;
                $display("[TB] FAIL reset_vals cyc%0d got st=%0d sb=%b byp=%b in=%b rdy=%b flt=%b mon=%0d want st=0 sb=0 byp=1 in=1 rdy=0 flt=0 mon=0",
                         i, st_code, dg_sb, dg_byp, dg_in, ready, fault, mon_edges);
            end
        end
    endtask

    task automatic test_bringup();
        logic [2:0] last;
        logic [2:0] exp_st;
        int wake_n = 0;
        mode = 0;
        exp_q.push_back(3'd1); exp_q.push_back(3'd2); exp_q.push_back(3'd3); exp_q.push_back(3'd4);
        enable = 1'b1;
        last = st_code;
        for (int b = 0; b < 400 && exp_q.size() > 0; b++) begin
            @(negedge clk);
            if (st_code == 3'd1) wake_n++;
            if (st_code !== last) begin
                exp_st = exp_q.pop_front();
                checks++;
                if (st_code !== exp_st) begin
                    errors++;
                    $display("[TB] FAIL bringup_state got %0d want %0d", st_code, exp_st);
                end
                last = st_code;
            end
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL bringup_timeout got %0d states pending want 0", exp_q.size());
            exp_q.delete();
        end
        checks++;
        if (wake_n != 16) begin
            errors++;
            $display("[TB] FAIL wake_cycles got %0d want 16", wake_n);
        end
        checks++;
        if ({ready, fault, dg_sb} !== 3'b101) begin
            errors++;
            $display("[TB] FAIL run_flags got rdy=%b flt=%b sb=%b want 1 0 1", ready, fault, dg_sb);
        end
        pad_in = 1'b0; #1;
        checks++;
        if (dg_in !== 1'b0) begin
            errors++;
            $display("[TB] FAIL pad_pass_lo got %b want 0", dg_in);
        end
        pad_in = 1'b1; #1;
        checks++;
        if (dg_in !== 1'b1) begin
            errors++;
            $display("[TB] FAIL pad_pass_hi got %b want 1", dg_in);
        end
    endtask

    task automatic test_byp();
        @(negedge clk);
        checks++;
        if (dg_byp !== 1'b0) begin
            errors++;
            $display("[TB] FAIL byp_run_init got %b want 0", dg_byp);
        end
        cfg_byp = 1'b1; #1;
        checks++;
        if (dg_byp !== 1'b0) begin
            errors++;
            $display("[TB] FAIL byp_not_yet got %b want 0", dg_byp);
        end
        @(negedge clk);
        checks++;
        if (dg_byp !== 1'b1) begin
            errors++;
            $display("[TB] FAIL byp_set got %b want 1", dg_byp);
        end
        cfg_byp = 1'b0;
        @(negedge clk);
        checks++;
        if (dg_byp !== 1'b0) begin
            errors++;
            $display("[TB] FAIL byp_clr got %b want 0", dg_byp);
        end
    endtask

    task automatic test_mon();
        int exp_m;
        repeat (10) @(negedge clk);
        mon_clr = 1'b1;
        @(negedge clk);
        mon_clr = 1'b0;
        checks++;
        if (mon_edges !== 16'd0) begin
            errors++;
            $display("[TB] FAIL mon_clear got %0d want 0", mon_edges);
        end
        for (int i = 0; i < 10; i++) begin
            pad_in = ~pad_in;
            repeat (4) @(negedge clk);
        end
        mon_q.push_back(mon_exp(10));
        repeat (8) @(negedge clk);
        exp_m = mon_q.pop_front();
        checks++;
        if (mon_edges !== 16'(exp_m)) begin
            errors++;
            $display("[TB] FAIL mon_count10 got %0d want %0d", mon_edges, exp_m);
        end
        // Pad toggle reaches dg_out_s after 5 edges and is counted on the 6th; clear lands on that edge.
        pad_in = ~pad_in;
        mon_q.push_back(mon_exp(10));
        mon_q.push_back(0);
        repeat (5) @(negedge clk);
        exp_m = mon_q.pop_front();
        checks++;
        if (mon_edges !== 16'(exp_m)) begin
            errors++;
            $display("[TB] FAIL mon_pre_clr got %0d want %0d", mon_edges, exp_m);
        end
        mon_clr = 1'b1;
        @(negedge clk);
        mon_clr = 1'b0;
        exp_m = mon_q.pop_front();
        checks++;
        if (mon_edges !== 16'(exp_m)) begin
            errors++;
            $display("[TB] FAIL mon_clr_priority got %0d want %0d", mon_edges, exp_m);
        end
        pad_in = ~pad_in;
        mon_q.push_back(mon_exp(1));
        repeat (8) @(negedge clk);
        exp_m = mon_q.pop_front();
        checks++;
        if (mon_edges !== 16'(exp_m)) begin
            errors++;
            $display("[TB] FAIL mon_after_clr got %0d want %0d", mon_edges, exp_m);
        end
        enable = 1'b0;
        @(negedge clk);
        checks++;
        if ({st_code, ready, mon_edges} !== {3'd0, 1'b0, 16'd0}) begin
            errors++;
            $display("[TB] FAIL run_to_off got st=%0d rdy=%b mon=%0d want st=0 rdy=0 mon=0", st_code, ready, mon_edges);
        end
    endtask

    task automatic test_fault_lo();
        logic [2:0] last;
        logic [2:0] exp_st;
        int lo_n = 0;
        mode = 1;
        exp_q.push_back(3'd1); exp_q.push_back(3'd2); exp_q.push_back(3'd5);
        enable = 1'b1;
        last = st_code;
        for (int b = 0; b < 400 && exp_q.size() > 0; b++) begin
            @(negedge clk);
            if (st_code == 3'd2) lo_n++;
            if (st_code !== last) begin
                exp_st = exp_q.pop_front();
                checks++;
                if (st_code !== exp_st) begin
                    errors++;
                    $display("[TB] FAIL flo_state got %0d want %0d", st_code, exp_st);
                end
                last = st_code;
            end
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL flo_timeout got %0d states pending want 0", exp_q.size());
            exp_q.delete();
        end
        checks++;
        if (lo_n != 64) begin
            errors++;
            $display("[TB] FAIL flo_cycles got %0d want 64", lo_n);
        end
        repeat (5) @(negedge clk);
        checks++;
        if ({st_code, fault, dg_sb, dg_byp, ready} !== {3'd5, 4'b1010}) begin
            errors++;
            $display("[TB] FAIL flo_hold got st=%0d flt=%b sb=%b byp=%b rdy=%b want st=5 flt=1 sb=0 byp=1 rdy=0",
                     st_code, fault, dg_sb, dg_byp, ready);
        end
        enable = 1'b0;
        @(negedge clk);
        checks++;
        if ({st_code, fault} !== {3'd0, 1'b0}) begin
            errors++;
            $display("[TB] FAIL fault_to_off got st=%0d flt=%b want st=0 flt=0", st_code, fault);
        end
        mode = 0;
    endtask

    task automatic test_fault_hi();
        logic [2:0] last;
        logic [2:0] exp_st;
        int  hi_n = 0;
        bit  saw_ready = 1'b0;
        mode = 2;
        exp_q.push_back(3'd1); exp_q.push_back(3'd2); exp_q.push_back(3'd3); exp_q.push_back(3'd5);
        enable = 1'b1;
        last = st_code;
        for (int b = 0; b < 400 && exp_q.size() > 0; b++) begin
            @(negedge clk);
            if (st_code == 3'd3) hi_n++;
            if (ready) saw_ready = 1'b1;
            if (st_code !== last) begin
                exp_st = exp_q.pop_front();
                checks++;
                if (st_code !== exp_st) begin
                    errors++;
                    $display("[TB] FAIL fhi_state got %0d want %0d", st_code, exp_st);
                end
                last = st_code;
            end
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL fhi_timeout got %0d states pending want 0", exp_q.size());
            exp_q.delete();
        end
        checks++;
        if (hi_n != 64) begin
            errors++;
            $display("[TB] FAIL fhi_cycles got %0d want 64", hi_n);
        end
        checks++;
        if (saw_ready || fault !== 1'b1) begin
            errors++;
            $display("[TB] FAIL fhi_flags got saw_ready=%b flt=%b want 0 1", saw_ready, fault);
        end
        enable = 1'b0;
        @(negedge clk);
        mode = 0;
    endtask

    task automatic test_rst_mid();
        int b;
        mode = 0;
        enable = 1'b1;
        for (b = 0; b < 100 && st_code != 3'd2; b++) @(negedge clk);
        checks++;
        if (st_code !== 3'd2) begin
            errors++;
            $display("[TB] FAIL rstmid_reach got st=%0d want 2", st_code);
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({st_code, dg_sb, dg_byp, dg_in, ready, fault} !== {3'd0, 5'b01100}) begin
            errors++;
            $display("[TB] FAIL rstmid_vals got st=%0d sb=%b byp=%b in=%b rdy=%b flt=%b want st=0 sb=0 byp=1 in=1 rdy=0 flt=0",
                     st_code, dg_sb, dg_byp, dg_in, ready, fault);
        end
        rst = 1'b0;
        enable = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_bringup();
        test_byp();
        test_mon();
        test_fault_lo();
        test_fault_hi();
        test_rst_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
